audio_sample_pacer: RTL and testbench

Upstream feeder for the 44.1 kHz audio output stage. Accepts packed stereo PCM samples from a producer (CPU, ROM player, synth) over a valid/ready handshake and buffers them in a small FIFO. Releases exactly one sample per 44.1 kHz period as a one-cycle `wreq` plus a stable `sample` bus, paced by an exact fractional phase accumulator on the system clock. On underrun it flags the condition instead of stalling the DAC.

---
 rtl/audio_pkg.sv | 28 ++
 rtl/audio_sample_fifo.sv | 69 ++++++
 rtl/audio_sample_pacer.sv | 91 +++++++++
 tb/tb_audio_sample_pacer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared constants and helpers for the 44.1 kHz audio sample pacer.
// Optional build macro (used by the top level): AUDIO_PACER_UNDERRUN_MUTE_EN.
package audio_pkg;

    localparam int DEFAULT_AUDIO_BITS = 12;
    localparam int DEFAULT_CLK_HZ     = 50_000_000;
    localparam int DEFAULT_SAMPLE_HZ  = 44_100;
    localparam int DEFAULT_FIFO_AW    = 4;

    // Stereo words are packed {left, right}; right channel sits at bit 0.
    localparam int MAX_STEREO_W = 64;
    localparam int RIGHT_LSB    = 0;

    function automatic int stereo_width(input int bits);
        return 2 * bits;
    endfunction

    function automatic int left_lsb(input int bits);
        return RIGHT_LSB + bits;
    endfunction

    // Unsigned midscale per channel: only the MSB of each channel set.
    function automatic logic [MAX_STEREO_W-1:0] midscale(input int bits);
        return (64'(1) << (left_lsb(bits) + bits - 1))
             | (64'(1) << (RIGHT_LSB + bits - 1));
    endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous FIFO with registered fill/full/empty flags.
// No write-to-read bypass: a word is visible to pop the cycle after it is written.
module audio_sample_fifo #(
    parameter int DW = 24,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          aclr,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] rd_data,
    output logic [AW:0]   fill,
    output logic          full,
    output logic          empty
);

    localparam int        DEPTH    = 1 << AW;
    localparam logic [AW:0] FILL_MAX = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fill_next;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        // NOTE: default assignment first so no path leaves fill_next unassigned (no latch).
        fill_next = fill;
        if (do_push && !do_pop) begin
            fill_next = fill + 1'b1;
        end else if (do_pop && !do_push) begin
            fill_next = fill - 1'b1;
        end
    end

    // NOTE: storage is not reset; pointers and fill make stale words unreachable.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fill  <= fill_next;
            full  <= (fill_next == FILL_MAX);
            empty <= (fill_next == '0);
        end
    end

endmodule

// File: rtl/audio_sample_pacer.sv
// Buffers producer samples and releases one per SAMPLE_HZ period via a fractional accumulator.
// Build macro AUDIO_PACER_UNDERRUN_MUTE_EN: underrun (and reset) loads midscale instead of holding.
module audio_sample_pacer
    import audio_pkg::*;
#(
    parameter int AUDIO_BITS = DEFAULT_AUDIO_BITS,
    parameter int CLK_HZ     = DEFAULT_CLK_HZ,
    parameter int SAMPLE_HZ  = DEFAULT_SAMPLE_HZ,
    parameter int FIFO_AW    = DEFAULT_FIFO_AW
) (
    input  logic                    clk,
    input  logic                    aclr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*AUDIO_BITS-1:0] in_sample,
    output logic                    wreq,
    output logic [2*AUDIO_BITS-1:0] sample,
    output logic [FIFO_AW:0]        fill,
    output logic                    underrun,
    input  logic                    underrun_clr
);

    localparam int SW    = stereo_width(AUDIO_BITS);
    localparam int ACC_W = $clog2(CLK_HZ) + 1;

    localparam logic [ACC_W-1:0] CLK_K  = ACC_W'(CLK_HZ);
    localparam logic [ACC_W-1:0] STEP_K = ACC_W'(SAMPLE_HZ);

`ifdef AUDIO_PACER_UNDERRUN_MUTE_EN
    localparam logic [SW-1:0] IDLE_SAMPLE = SW'(midscale(AUDIO_BITS));
`else
    localparam logic [SW-1:0] IDLE_SAMPLE = '0;
`endif

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic             tick;
    logic [SW-1:0]    head;
    logic             full;
    logic             empty;

    // acc stays below CLK_HZ, so acc + SAMPLE_HZ cannot overflow ACC_W bits.
    assign acc_sum  = acc + STEP_K;
    assign tick     = (acc_sum >= CLK_K);
    assign in_ready = !full;

    audio_sample_fifo #(
        .DW (SW),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .aclr    (aclr),
        .push    (in_valid),
        .pop     (tick),
        .wr_data (in_sample),
        .rd_data (head),
        .fill    (fill),
        .full    (full),
        .empty   (empty)
    );

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            acc      <= '0;
            wreq     <= 1'b0;
            sample   <= IDLE_SAMPLE;
            underrun <= 1'b0;
        end else begin
            acc  <= tick ? (acc_sum - CLK_K) : acc_sum;
            wreq <= tick;
            if (tick) begin
                if (!empty) begin
                    sample <= head;
                end
`ifdef AUDIO_PACER_UNDERRUN_MUTE_EN
                else begin
                    sample <= IDLE_SAMPLE;
                end
`endif
            end
            // A new underrun takes priority over a simultaneous clear.
            if (tick && empty) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_audio_sample_pacer.sv
// Directed bench for audio_sample_pacer: reset, pacing, full FIFO, underrun and mid-run reset.
module tb_audio_sample_pacer;

    localparam int AUDIO_BITS = 12;
    localparam int CLK_HZ     = 50_000_000;
    localparam int SAMPLE_HZ  = 44_100;
    localparam int FIFO_AW    = 4;
    localparam int WAIT_LIMIT = 1200;

`ifdef AUDIO_PACER_UNDERRUN_MUTE_EN
    localparam logic [23:0] IDLE = 24'h800800;
`else
    localparam logic [23:0] IDLE = 24'h000000;
`endif

    logic        clk = 1'b0;
    logic        aclr = 1'b0;
    logic        in_valid = 1'b0;
    logic        underrun_clr = 1'b0;
    logic [23:0] in_sample = '0;
    logic        in_ready;
    logic        wreq;
    logic [23:0] sample;
    logic [4:0]  fill;
    logic        underrun;

    int pass_cnt = 0;
    int total_cnt = 0;
    int edge_cnt;

    audio_sample_pacer #(
        .AUDIO_BITS (AUDIO_BITS),
        .CLK_HZ     (CLK_HZ),
        .SAMPLE_HZ  (SAMPLE_HZ),
        .FIFO_AW    (FIFO_AW)
    ) dut (
        .clk          (clk),
        .aclr         (aclr),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sample    (in_sample),
        .wreq         (wreq),
        .sample       (sample),
        .fill         (fill),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    always #5 clk = ~clk;

    // Rising edges since the last reset release.
    always @(posedge clk or posedge aclr) begin
        if (aclr) edge_cnt <= 0;
        else      edge_cnt <= edge_cnt + 1;
    end

    // Edge on which the n-th wreq appears: ceil(n * CLK_HZ / SAMPLE_HZ).
    function automatic int tick_edge(input int n);
        return int'((longint'(n) * CLK_HZ + SAMPLE_HZ - 1) / SAMPLE_HZ);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int e);
        while (edge_cnt < e) step();
    endtask

    task automatic wait_wreq(output bit found);
        found = 1'b0;
        for (int i = 0; i < WAIT_LIMIT && !found; i++) begin
            step();
            found = wreq;
        end
    endtask

    task automatic do_reset();
        aclr = 1'b1;
        in_valid = 1'b0;
        underrun_clr = 1'b0;
        in_sample = '0;
        step();
        step();
        #3 aclr = 1'b0;
    endtask

    task automatic test_reset();
        bit found;
        #2 aclr = 1'b1;
        step();
        step();
        total_cnt++; if (wreq !== 1'b0) $display("FAIL reset_wreq: got %b want 0", wreq); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (fill !== 5'd0) $display("FAIL reset_fill: got %0d want 0", fill); else pass_cnt++;
        total_cnt++; if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b want 0", underrun); else pass_cnt++;
        total_cnt++; if (sample !== IDLE) $display("FAIL reset_sample: got %h want %h", sample, IDLE); else pass_cnt++;
        in_sample = 24'hABC123;
        in_valid = 1'b1;
        #3 aclr = 1'b0;
        step();
        in_valid = 1'b0;
        total_cnt++; if (fill !== 5'd1) $display("FAIL preload_fill: got %0d want 1", fill); else pass_cnt++;
        wait_wreq(found);
        total_cnt++; if (!found || edge_cnt !== 1134) $display("FAIL first_pulse_edge: got %0d (found=%b) want 1134", edge_cnt, found); else pass_cnt++;
        total_cnt++; if (sample !== 24'hABC123) $display("FAIL first_pulse_sample: got %h want abc123", sample); else pass_cnt++;
        total_cnt++; if (fill !== 5'd0) $display("FAIL first_pulse_fill: got %0d want 0", fill); else pass_cnt++;
        total_cnt++; if (underrun !== 1'b0) $display("FAIL first_pulse_underrun: got %b want 0", underrun); else pass_cnt++;
        step();
        total_cnt++; if (wreq !== 1'b0) $display("FAIL wreq_one_cycle: got %b want 0", wreq); else pass_cnt++;
    endtask

    task automatic test_rate();
        bit found;
        int prev;
        int gap;
        do_reset();
        in_sample = 24'h5A5A5A;
        in_valid = 1'b1;
        prev = 0;
        for (int n = 1; n <= 30; n++) begin
            wait_wreq(found);
            total_cnt++;
            if (!found || edge_cnt !== tick_edge(n))
                $display("FAIL rate_edge_%0d: got %0d (found=%b) want %0d", n, edge_cnt, found, tick_edge(n));
            else pass_cnt++;
            gap = edge_cnt - prev;
            if (n > 1) begin
                total_cnt++;
                if (gap != 1133 && gap != 1134) $display("FAIL rate_gap_%0d: got %0d want 1133 or 1134", n, gap);
                else pass_cnt++;
            end
            prev = edge_cnt;
        end
        in_valid = 1'b0;
        total_cnt++; if (underrun !== 1'b0) $display("FAIL rate_underrun: got %b want 0", underrun); else pass_cnt++;
    endtask

    task automatic test_full();
        bit found;
        do_reset();
        in_sample = 24'd1;
        in_valid = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            in_sample = 24'(i + 1);
        end
        total_cnt++; if (fill !== 5'd16) $display("FAIL full_fill: got %0d want 16", fill); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL full_in_ready: got %b want 0", in_ready); else pass_cnt++;
        run_to(tick_edge(1) - 1);
        total_cnt++; if (fill !== 5'd16) $display("FAIL full_hold_fill: got %0d want 16", fill); else pass_cnt++;
        step();
        total_cnt++; if (wreq !== 1'b1 || sample !== 24'd1) $display("FAIL full_first_pop: got wreq=%b sample=%h want 1/000001", wreq, sample); else pass_cnt++;
        total_cnt++; if (fill !== 5'd15) $display("FAIL full_after_pop_fill: got %0d want 15", fill); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL full_ready_rise: got %b want 1", in_ready); else pass_cnt++;
        step();
        in_valid = 1'b0;
        total_cnt++; if (fill !== 5'd16 || in_ready !== 1'b0) $display("FAIL full_17th_accept: got fill=%0d ready=%b want 16/0", fill, in_ready); else pass_cnt++;
        wait_wreq(found);
        total_cnt++; if (!found || sample !== 24'd2) $display("FAIL full_second_pop: got %h (found=%b) want 000002", sample, found); else pass_cnt++;
    endtask

    task automatic test_underrun();
        do_reset();
        in_sample = 24'h123456;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        run_to(tick_edge(1));
        total_cnt++; if (wreq !== 1'b1 || sample !== 24'h123456) $display("FAIL ur_first: got wreq=%b sample=%h want 1/123456", wreq, sample); else pass_cnt++;
        total_cnt++; if (underrun !== 1'b0) $display("FAIL ur_not_yet: got %b want 0", underrun); else pass_cnt++;
        run_to(tick_edge(2) - 1);
        in_sample = 24'h654321;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        total_cnt++; if (wreq !== 1'b1) $display("FAIL ur_wreq: got %b want 1", wreq); else pass_cnt++;
        total_cnt++; if (underrun !== 1'b1) $display("FAIL ur_set: got %b want 1", underrun); else pass_cnt++;
`ifdef AUDIO_PACER_UNDERRUN_MUTE_EN
        total_cnt++; if (sample !== 24'h800800) $display("FAIL ur_sample: got %h want 800800", sample); else pass_cnt++;
`else
        total_cnt++; if (sample !== 24'h123456) $display("FAIL ur_sample: got %h want 123456", sample); else pass_cnt++;
`endif
        total_cnt++; if (fill !== 5'd1) $display("FAIL ur_no_bypass_fill: got %0d want 1", fill); else pass_cnt++;
        step();
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        total_cnt++; if (underrun !== 1'b0) $display("FAIL ur_clear: got %b want 0", underrun); else pass_cnt++;
        run_to(tick_edge(3));
        total_cnt++; if (wreq !== 1'b1 || sample !== 24'h654321) $display("FAIL ur_stored_pop: got wreq=%b sample=%h want 1/654321", wreq, sample); else pass_cnt++;
        total_cnt++; if (underrun !== 1'b0 || fill !== 5'd0) $display("FAIL ur_after_pop: got ur=%b fill=%0d want 0/0", underrun, fill); else pass_cnt++;
    endtask

    task automatic test_underrun_clr_same_cycle();
        underrun_clr = 1'b1;
        run_to(tick_edge(4) - 1);
        total_cnt++; if (underrun !== 1'b0) $display("FAIL urc_pre: got %b want 0", underrun); else pass_cnt++;
        step();
        underrun_clr = 1'b0;
        total_cnt++; if (wreq !== 1'b1 || underrun !== 1'b1) $display("FAIL urc_set_wins: got wreq=%b ur=%b want 1/1", wreq, underrun); else pass_cnt++;
        step();
        total_cnt++; if (underrun !== 1'b1) $display("FAIL urc_sticky: got %b want 1", underrun); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit found;
        do_reset();
        in_sample = 24'h0F0F0F;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) step();
        in_valid = 1'b0;
        run_to(100);
        total_cnt++; if (fill !== 5'd5) $display("FAIL mid_pre_fill: got %0d want 5", fill); else pass_cnt++;
        #2 aclr = 1'b1;
        #1;
        total_cnt++; if (fill !== 5'd0 || wreq !== 1'b0) $display("FAIL mid_reset: got fill=%0d wreq=%b want 0/0", fill, wreq); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL mid_reset_ready: got %b want 1", in_ready); else pass_cnt++;
        step();
        #3 aclr = 1'b0;
        wait_wreq(found);
        total_cnt++; if (!found || edge_cnt !== 1134) $display("FAIL mid_next_pulse: got %0d (found=%b) want 1134", edge_cnt, found); else pass_cnt++;
        total_cnt++; if (underrun !== 1'b1 || fill !== 5'd0) $display("FAIL mid_discarded: got ur=%b fill=%0d want 1/0", underrun, fill); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_rate();
        test_full();
        test_underrun();
        test_underrun_clr_same_cycle();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
